seq_alu: RTL

Parametrised, registered successor to the combinational accumulator ALU. Each operation latches `acc_data`, `mem_data` and `arg_data` on an input handshake and returns a registered result with zero and carry flags on an output handshake. Multi-bit shifts run serially, one bit per cycle, with the shift amount taken from `arg_data`. The block sits between the accumulator/memory read path and the accumulator write-back in the datapath.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_serial_shift.sv | 56 +++++
 rtl/seq_alu.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential accumulator ALU.
// Holds the operation-code enum and the control FSM state enum.
package alu_pkg;

    localparam int OP_W = 3;

    // Operation codes carried on the op input.
    typedef enum logic [OP_W-1:0] {
        OP_READ = 3'd0,
        OP_NAND = 3'd1,
        OP_SHR  = 3'd2,
        OP_SHL  = 3'd3,
        OP_ADD  = 3'd4
    } op_e;

    // Control FSM states of seq_alu.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_serial_shift.sv
// alu_serial_shift: serial one-bit-per-cycle shifter for seq_alu.
// Holds the work register, the down-counter of remaining steps and the
// direction bit. The top-level FSM loads it once per shift and then steps it
// until the counter reaches zero.
module alu_serial_shift
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_dir_left,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNT_W-1:0] i_amount,
    output logic [WIDTH-1:0] o_work_next,
    output logic             o_zero_cnt,
    output logic             o_last_step
);

    logic [WIDTH-1:0] r_work;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir_left;
    logic [WIDTH-1:0] w_work_next;

    // Value of the work register after one more step, zero-filled.
    assign w_work_next = r_dir_left ? {r_work[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_work[WIDTH-1:1]};

    // Load operand, amount and direction; then shift and count down per step.
    always_ff @(posedge clk) begin
        // NOTE: every register here is small and gets a real reset value, so an
        // aborted shift never leaves stale counter state behind.
        if (!rst_n) begin
            r_work     <= '0;
            r_cnt      <= '0;
            r_dir_left <= 1'b0;
        end else if (i_load) begin
            r_work     <= i_data;
            r_cnt      <= i_amount;
            r_dir_left <= i_dir_left;
        end else if (i_step) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, regardless of statement order.
            r_work <= w_work_next;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    assign o_work_next = w_work_next;
    assign o_zero_cnt  = (r_cnt == '0);
    assign o_last_step = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered accumulator ALU with a valid/ready handshake on both
// sides. READ, NAND and (optionally) ADD complete in one cycle; SHR/SHL run
// serially through alu_serial_shift, one bit per cycle.
// Optional feature: define SEQ_ALU_ADD_EN to make op 4 an ADD with carry-out;
// without it op 4 is illegal and carry is tied to 0.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] acc_data,
    input  logic [WIDTH-1:0] mem_data,
    input  logic [WIDTH-1:0] arg_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             is_zero,
    output logic             carry,
    output logic             illegal_op
);

    state_e           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_is_zero;
    logic             r_illegal;

    logic             w_accept;
    logic             w_is_shift;
    logic [CNT_W-1:0] w_shift_amt;
    logic             w_start_shift;
    logic [WIDTH-1:0] w_single_result;
    logic             w_single_illegal;
    logic [WIDTH-1:0] w_work_next;
    logic             w_zero_cnt;
    logic             w_last_step;

`ifdef SEQ_ALU_ADD_EN
    logic             r_carry;
    logic [WIDTH:0]   w_sum;
    logic             w_single_carry;

    assign w_sum = {1'b0, acc_data} + {1'b0, mem_data};
`endif

    assign w_accept   = in_valid && (r_state == ST_IDLE);
    assign w_is_shift = (op == OP_SHR) || (op == OP_SHL);

    // Shift amount saturates at WIDTH, which shifts everything out.
    assign w_shift_amt   = (arg_data >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH)
                                                       : arg_data[CNT_W-1:0];
    assign w_start_shift = w_accept && w_is_shift && (w_shift_amt != '0);

    // Result of ops that finish on the accept edge (including zero-length shifts).
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would infer a latch.
        w_single_result  = acc_data;
        w_single_illegal = 1'b0;
`ifdef SEQ_ALU_ADD_EN
        w_single_carry   = 1'b0;
`endif
        case (op)
            OP_READ: w_single_result = acc_data;
            OP_NAND: w_single_result = ~(acc_data & mem_data);
            OP_SHR,
            OP_SHL:  w_single_result = acc_data;
`ifdef SEQ_ALU_ADD_EN
            OP_ADD: begin
                w_single_result = w_sum[WIDTH-1:0];
                w_single_carry  = w_sum[WIDTH];
            end
`endif
            default: w_single_illegal = 1'b1;
        endcase
    end

    alu_serial_shift #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_start_shift),
        .i_step      ((r_state == ST_SHIFT) && !w_zero_cnt),
        .i_dir_left  (op == OP_SHL),
        .i_data      (acc_data),
        .i_amount    (w_shift_amt),
        .o_work_next (w_work_next),
        .o_zero_cnt  (w_zero_cnt),
        .o_last_step (w_last_step)
    );

    // Control FSM with registered result, flags and handshake state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_result  <= '0;
            r_is_zero <= 1'b1;
            r_illegal <= 1'b0;
`ifdef SEQ_ALU_ADD_EN
            r_carry   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_shift) begin
                        r_state <= ST_SHIFT;
                    end else if (w_accept) begin
                        r_state   <= ST_DONE;
                        r_result  <= w_single_result;
                        r_is_zero <= (w_single_result == '0);
                        r_illegal <= w_single_illegal;
`ifdef SEQ_ALU_ADD_EN
                        r_carry   <= w_single_carry;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (w_last_step) begin
                        r_state   <= ST_DONE;
                        r_result  <= w_work_next;
                        r_is_zero <= (w_work_next == '0);
                        r_illegal <= 1'b0;
`ifdef SEQ_ALU_ADD_EN
                        r_carry   <= 1'b0;
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign result     = r_result;
    assign is_zero    = r_is_zero;
    assign illegal_op = r_illegal;
`ifdef SEQ_ALU_ADD_EN
    assign carry      = r_carry;
`else
    assign carry      = 1'b0;
`endif

endmodule
